// File: rtl/ring_input_buffer_if.sv
// ring_input_buffer_if
// Link-side and consumer-side signals of one ring input buffer, bundled.
//   polarity  : global phase (1 = even VC link-write / odd VC drain)
//   si/ri/di  : upstream link send strobe, ready, packet
//   request_* : per-VC Moore requests to PE ejection / onward hop
//   grant_*   : per-VC consumer acceptance
//   data_out_*: per-VC stored packet
//   vc_err    : sticky VC/phase mismatch flag
// modport master = upstream link + consumers, modport slave = the buffer.
interface ring_input_buffer_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  polarity;
  logic                  si;
  logic                  ri;
  logic [DATA_WIDTH-1:0] di;
  logic                  request_pe_even;
  logic                  request_pe_odd;
  logic                  request_fwd_even;
  logic                  request_fwd_odd;
  logic                  grant_pe_even;
  logic                  grant_pe_odd;
  logic                  grant_fwd_even;
  logic                  grant_fwd_odd;
  logic [DATA_WIDTH-1:0] data_out_even;
  logic [DATA_WIDTH-1:0] data_out_odd;
  logic                  vc_err;

  modport master (
    output polarity, si, di,
    output grant_pe_even, grant_pe_odd, grant_fwd_even, grant_fwd_odd,
    input  ri,
    input  request_pe_even, request_pe_odd, request_fwd_even, request_fwd_odd,
    input  data_out_even, data_out_odd, vc_err
  );

  modport slave (
    input  polarity, si, di,
    input  grant_pe_even, grant_pe_odd, grant_fwd_even, grant_fwd_odd,
    output ri,
    output request_pe_even, request_pe_odd, request_fwd_even, request_fwd_odd,
    output data_out_even, data_out_odd, vc_err
  );
endinterface

// File: rtl/ring_input_buffer.sv
// ring_input_buffer
// Two single-entry buffers (even VC, odd VC) at a ring node input. The
// phase-selected VC accepts a packet from the upstream link; the other VC
// is drained by either the local PE or the onward ring hop.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : ring_input_buffer_if.slave (link, requests, grants, data, vc_err)
// Packet fields: bit 63 = VC (0 even, 1 odd), bits 55:48 = remaining hops.
module ring_input_buffer #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic                 clk,
  input logic                 rst,
  ring_input_buffer_if.slave  bus
);

  localparam int unsigned VC_BIT = 63;
  localparam int unsigned HOP_HI = 55;
  localparam int unsigned HOP_LO = 48;

  localparam logic [1:0] EMPTY    = 2'd0;
  localparam logic [1:0] FULL_PE  = 2'd1;
  localparam logic [1:0] FULL_FWD = 2'd2;

  // index 0 = even VC, index 1 = odd VC
  logic [1:0]            state_q [2];
  logic [DATA_WIDTH-1:0] data_q  [2];
  logic                  vc_err_q;

  logic [1:0]            grant_pe;
  logic [1:0]            grant_fwd;
  logic [1:0]            drain;
  logic [1:0]            cap;
  logic                  wr_fire;
  logic                  vc_ok;
  logic [7:0]            hop;
  logic                  hop_zero;
  logic [DATA_WIDTH-1:0] cap_data;

  assign grant_pe  = {bus.grant_pe_odd,  bus.grant_pe_even};
  assign grant_fwd = {bus.grant_fwd_odd, bus.grant_fwd_even};

  // Ready only for the phase-selected VC and never during reset.
  assign bus.ri = ~rst & (bus.polarity ? (state_q[0] == EMPTY)
                                       : (state_q[1] == EMPTY));

  always_comb begin
    wr_fire  = bus.si & bus.ri;
    // polarity=1 expects even (bit 63 = 0); polarity=0 expects odd (bit 63 = 1)
    vc_ok    = (bus.di[VC_BIT] != bus.polarity);
    hop      = bus.di[HOP_HI:HOP_LO];
    hop_zero = (hop == 8'd0);
    cap_data = bus.di;
    if (!hop_zero) begin
      cap_data[HOP_HI:HOP_LO] = hop >> 1;
    end
    cap = {wr_fire & vc_ok & ~bus.polarity, wr_fire & vc_ok & bus.polarity};
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc
    // A grant only counts when it matches the current request.
    assign drain[v] = ((state_q[v] == FULL_PE)  & grant_pe[v]) |
                      ((state_q[v] == FULL_FWD) & grant_fwd[v]);

    // cap and drain never hit the same VC together: ri requires EMPTY.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q[v] <= EMPTY;
        data_q[v]  <= '0;
      end else if (drain[v]) begin
        state_q[v] <= EMPTY;
      end else if (cap[v]) begin
        state_q[v] <= hop_zero ? FULL_PE : FULL_FWD;
        data_q[v]  <= cap_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vc_err_q <= 1'b0;
    end else if (wr_fire & ~vc_ok) begin
      vc_err_q <= 1'b1;
    end
  end

  assign bus.request_pe_even  = (state_q[0] == FULL_PE);
  assign bus.request_fwd_even = (state_q[0] == FULL_FWD);
  assign bus.request_pe_odd   = (state_q[1] == FULL_PE);
  assign bus.request_fwd_odd  = (state_q[1] == FULL_FWD);
  assign bus.data_out_even    = data_q[0];
  assign bus.data_out_odd     = data_q[1];
  assign bus.vc_err           = vc_err_q;

endmodule

// File: tb/tb_ring_input_buffer.sv
// tb_ring_input_buffer
// Directed-vector self-checking bench for ring_input_buffer.
module tb_ring_input_buffer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ring_input_buffer_if #(.DATA_WIDTH(64)) bus ();

  ring_input_buffer #(.DATA_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_grants();
    bus.grant_pe_even  = 1'b0;
    bus.grant_pe_odd   = 1'b0;
    bus.grant_fwd_even = 1'b0;
    bus.grant_fwd_odd  = 1'b0;
  endtask

  task automatic check_reqs(input string tag, input logic [3:0] exp);
    // order: pe_even, fwd_even, pe_odd, fwd_odd
    check_eq(tag, {60'd0, bus.request_pe_even, bus.request_fwd_even,
                   bus.request_pe_odd, bus.request_fwd_odd}, {60'd0, exp});
  endtask

  logic [63:0] pkt;
  logic [63:0] held;
  logic [15:0] e_seq;
  logic [15:0] o_seq;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.polarity = 1'b1;
    bus.si = 1'b0;
    bus.di = '0;
    clear_grants();

    // reset state; si and grants ignored while in reset
    bus.si = 1'b1;
    bus.grant_pe_even = 1'b1;
    tick();
    tick();
    check_eq("rst_ri", {63'd0, bus.ri}, 64'd0);
    check_reqs("rst_reqs", 4'b0000);
    check_eq("rst_dout_even", bus.data_out_even, 64'd0);
    check_eq("rst_dout_odd", bus.data_out_odd, 64'd0);
    check_eq("rst_vc_err", {63'd0, bus.vc_err}, 64'd0);
    bus.si = 1'b0;
    clear_grants();
    rst = 1'b0;
    #1;
    check_eq("post_rst_ri", {63'd0, bus.ri}, 64'd1);

    // even VC, local ejection
    bus.polarity = 1'b1;
    bus.si = 1'b1;
    bus.di = 64'h0000_0000_0000_00AA;
    tick();
    bus.si = 1'b0;
    check_reqs("pe_even_req", 4'b1000);
    check_eq("pe_even_data", bus.data_out_even, 64'h0000_0000_0000_00AA);
    check_eq("pe_even_ri_full", {63'd0, bus.ri}, 64'd0);
    bus.grant_pe_even = 1'b1;
    tick();
    clear_grants();
    check_reqs("pe_even_drained", 4'b0000);
    check_eq("pe_even_ri_empty", {63'd0, bus.ri}, 64'd1);

    // odd VC, forward with hop 7 -> 3
    bus.polarity = 1'b0;
    bus.si = 1'b1;
    bus.di = 64'h8007_0000_0000_0011;
    tick();
    bus.si = 1'b0;
    check_reqs("fwd_odd_req", 4'b0001);
    check_eq("fwd_odd_data", bus.data_out_odd, 64'h8003_0000_0000_0011);
    // wrong-target grant ignored
    bus.grant_pe_odd = 1'b1;
    tick();
    clear_grants();
    check_reqs("fwd_odd_stray_pe", 4'b0001);
    bus.grant_fwd_odd = 1'b1;
    tick();
    clear_grants();
    check_reqs("fwd_odd_drained", 4'b0000);

    // hop 1 forwards as 0
    bus.polarity = 1'b1;
    bus.si = 1'b1;
    bus.di = 64'h0001_0000_0000_0005;
    tick();
    bus.si = 1'b0;
    check_reqs("hop1_req", 4'b0100);
    check_eq("hop1_data", bus.data_out_even, 64'h0000_0000_0000_0005);
    bus.grant_fwd_even = 1'b1;
    tick();
    clear_grants();

    // VC mismatch: dropped, sticky error
    bus.polarity = 1'b1;
    bus.si = 1'b1;
    bus.di = 64'h8000_0000_0000_0001;
    tick();
    bus.si = 1'b0;
    check_eq("vcerr_set", {63'd0, bus.vc_err}, 64'd1);
    check_reqs("vcerr_no_capture", 4'b0000);
    check_eq("vcerr_data_kept", bus.data_out_even, 64'h0000_0000_0000_0005);
    tick();
    tick();
    check_eq("vcerr_sticky", {63'd0, bus.vc_err}, 64'd1);

    // full buffer back-pressure, stray PE grant on a FWD entry
    bus.polarity = 1'b1;
    bus.si = 1'b1;
    bus.di = 64'h0004_0000_0000_1234;
    tick();
    held = 64'h0002_0000_0000_1234;
    bus.di = 64'h0000_0000_0000_9999;
    bus.grant_pe_even = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_ri", {63'd0, bus.ri}, 64'd0);
      check_eq("bp_data", bus.data_out_even, held);
      check_reqs("bp_req", 4'b0100);
      tick();
    end
    bus.si = 1'b0;
    clear_grants();
    bus.grant_fwd_even = 1'b1;
    tick();
    clear_grants();
    check_reqs("bp_drained", 4'b0000);

    // streaming: polarity toggles, grants always high
    e_seq = 16'h0100;
    o_seq = 16'h0200;
    bus.grant_pe_even  = 1'b1;
    bus.grant_pe_odd   = 1'b1;
    bus.grant_fwd_even = 1'b1;
    bus.grant_fwd_odd  = 1'b1;
    bus.si = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.polarity = (i % 2 == 0);
      pkt = bus.polarity ? {48'h0000_0000_0000, e_seq}
                         : {48'h8000_0000_0000, o_seq};
      bus.di = pkt;
      #1;
      check_eq("stream_ri", {63'd0, bus.ri}, 64'd1);
      tick();
      if (i % 2 == 0) begin
        check_eq("stream_even", bus.data_out_even, pkt);
        check_eq("stream_even_req", {63'd0, bus.request_pe_even}, 64'd1);
        e_seq = e_seq + 16'd1;
      end else begin
        check_eq("stream_odd", bus.data_out_odd, pkt);
        check_eq("stream_odd_req", {63'd0, bus.request_pe_odd}, 64'd1);
        o_seq = o_seq + 16'd1;
      end
    end
    bus.si = 1'b0;
    tick();
    clear_grants();
    check_eq("stream_even_count", {48'd0, e_seq}, 64'h0108);
    check_eq("stream_odd_count", {48'd0, o_seq}, 64'h0208);
    check_reqs("stream_end_empty", 4'b0000);

    // both full, then reset mid-operation
    bus.polarity = 1'b1;
    bus.si = 1'b1;
    bus.di = 64'h0000_0000_0000_00E1;
    tick();
    bus.polarity = 1'b0;
    bus.di = 64'h8003_0000_0000_00E2;
    tick();
    bus.si = 1'b0;
    check_reqs("both_full", 4'b1001);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ri_during", {63'd0, bus.ri}, 64'd0);
    tick();
    check_reqs("mid_rst_reqs", 4'b0000);
    check_eq("mid_rst_dout_even", bus.data_out_even, 64'd0);
    check_eq("mid_rst_dout_odd", bus.data_out_odd, 64'd0);
    check_eq("mid_rst_vc_err", {63'd0, bus.vc_err}, 64'd0);
    check_eq("mid_rst_ri_held", {63'd0, bus.ri}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_ri_after", {63'd0, bus.ri}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
